// File: rtl/axi_ram_burst_if.sv
// axi_ram_burst_if: AXI4 slave-side bundle for axi_ram_burst.
//   aw*/w*/b* : write address, write data, write response channels
//   ar*/r*    : read address, read data channels
// Modport slave is used by the RAM, master by whoever drives it.
interface axi_ram_burst_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]     s_axi_awid;
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_awlock;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ID_WIDTH-1:0]     s_axi_arid;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_arlock;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [ID_WIDTH-1:0]     s_axi_rid;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
           s_axi_wvalid, s_axi_bready, s_axi_arid, s_axi_araddr, s_axi_arlen,
           s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
           s_axi_wvalid, s_axi_bready, s_axi_arid, s_axi_araddr, s_axi_arlen,
           s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );
endinterface

// File: rtl/axi_ram_burst.sv
// axi_ram_burst: AXI4 burst RAM slave with independent read/write engines.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset (memory contents are kept)
//   s_axi : axi_ram_burst_if.slave (AW/W/B/AR/R channels)
// FIXED/INCR/WRAP bursts, byte strobes, SLVERR for illegal bursts and
// beats beyond DEPTH. Define AXI_RAM_BURST_EXCL_EN to build a single
// exclusive-access monitor (EXOKAY responses); otherwise lock is ignored.
module axi_ram_burst #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  axi_ram_burst_if.slave s_axi
);
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned MAX_SIZE = $clog2(STRB_W);
  localparam int unsigned MEM_AW   = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_BURST}         rd_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
  endfunction

  function automatic logic illegal_burst(input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] align;
    align = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    return (burst == 2'b11) ||
           ((burst == 2'b10) && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                                 ((addr & align) != '0)));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~mask) | ((addr + step) & mask);
      default: return addr + step;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr >> MAX_SIZE;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, word_of(addr)} < (ADDR_WIDTH+1)'(DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write engine ----------------
  wr_state_e             w_state_q, w_state_d;
  logic                  awready_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_ill_q, w_err_q;
  logic                  aw_hs, w_hs, w_beat_ok, w_we;
  logic [1:0]            bresp;

  // ---------------- read engine ----------------
  // Two registered stages: A holds the synchronous memory read, R drives the
  // channel. A refills whenever it is empty or handing over to R, giving
  // 1 beat/cycle and a stable R stage under back-pressure.
  rd_state_e             r_state_q, r_state_d;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   r_id_q, a_id_q, rid_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q, a_resp_q, rresp_q, rd_resp;
  logic                  r_ill_q, a_v_q, a_last_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] a_data_q, rdata_q;
  logic                  ar_hs, rd_issue, r_load, rd_beat_ok;

`ifdef AXI_RAM_BURST_EXCL_EN
  logic                  excl_v_q, r_excl_q, w_exok_q, w_block_q, excl_match;
  logic [ID_WIDTH-1:0]   excl_id_q;
  logic [ADDR_WIDTH-1:0] excl_word_q;
`endif

  logic unused_ok;
  always_comb unused_ok = ^{s_axi.s_axi_wlast, s_axi.s_axi_awlock, s_axi.s_axi_arlock};

  always_comb begin
    aw_hs      = s_axi.s_axi_awvalid && awready_q;
    w_hs       = s_axi.s_axi_wvalid && (w_state_q == W_BURST);
    w_beat_ok  = !w_ill_q && in_range(w_addr_q);
    w_we       = rst_n && w_hs && w_beat_ok;
    ar_hs      = s_axi.s_axi_arvalid && arready_q;
    r_load     = a_v_q && (!rvalid_q || s_axi.s_axi_rready);
    rd_issue   = rst_n && (r_state_q == R_BURST) && (!a_v_q || r_load);
    rd_beat_ok = !r_ill_q && in_range(r_addr_q);
    rd_resp    = rd_beat_ok ? 2'b00 : 2'b10;
    bresp      = w_err_q ? 2'b10 : 2'b00;
`ifdef AXI_RAM_BURST_EXCL_EN
    excl_match = excl_v_q && (excl_id_q == s_axi.s_axi_awid) &&
                 (excl_word_q == word_of(s_axi.s_axi_awaddr));
    w_we       = w_we && !w_block_q;
    if (rd_beat_ok && r_excl_q) rd_resp = 2'b01;
    if (!w_err_q && w_exok_q)   bresp   = 2'b01;
`endif
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_BURST;
      W_BURST: if (w_hs && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
      W_RESP:  if (s_axi.s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (rd_issue && (r_cnt_q == r_len_q)) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read sampled before the write lands: same-cycle read returns old data.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi.s_axi_wstrb[b])
          mem[MEM_AW'(word_of(w_addr_q))][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
      end
    end
    if (rd_issue) a_data_q <= rd_beat_ok ? mem[MEM_AW'(word_of(r_addr_q))] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_ill_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      if (aw_hs) begin
        w_id_q    <= s_axi.s_axi_awid;
        w_addr_q  <= s_axi.s_axi_awaddr;
        w_len_q   <= s_axi.s_axi_awlen;
        w_size_q  <= clamp_size(s_axi.s_axi_awsize);
        w_burst_q <= s_axi.s_axi_awburst;
        w_ill_q   <= illegal_burst(s_axi.s_axi_awaddr, s_axi.s_axi_awlen,
                                   clamp_size(s_axi.s_axi_awsize), s_axi.s_axi_awburst);
        w_err_q   <= 1'b0;
        w_cnt_q   <= '0;
      end
      if (w_hs) begin
        w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        w_cnt_q  <= w_cnt_q + 8'd1;
        if (!w_beat_ok) w_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_ill_q   <= 1'b0;
      a_v_q     <= 1'b0;
      a_last_q  <= 1'b0;
      a_resp_q  <= '0;
      a_id_q    <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_hs) begin
        r_id_q    <= s_axi.s_axi_arid;
        r_addr_q  <= s_axi.s_axi_araddr;
        r_len_q   <= s_axi.s_axi_arlen;
        r_size_q  <= clamp_size(s_axi.s_axi_arsize);
        r_burst_q <= s_axi.s_axi_arburst;
        r_ill_q   <= illegal_burst(s_axi.s_axi_araddr, s_axi.s_axi_arlen,
                                   clamp_size(s_axi.s_axi_arsize), s_axi.s_axi_arburst);
        r_cnt_q   <= '0;
      end
      if (rd_issue) begin
        a_v_q    <= 1'b1;
        a_last_q <= (r_cnt_q == r_len_q);
        a_resp_q <= rd_resp;
        a_id_q   <= r_id_q;
        r_addr_q <= next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        r_cnt_q  <= r_cnt_q + 8'd1;
      end else if (r_load) begin
        a_v_q <= 1'b0;
      end
      if (r_load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= a_data_q;
        rresp_q  <= a_resp_q;
        rlast_q  <= a_last_q;
        rid_q    <= a_id_q;
      end else if (s_axi.s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef AXI_RAM_BURST_EXCL_EN
  // Later assignments win: a new exclusive read re-arms the monitor even if
  // a write clears it in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      excl_v_q    <= 1'b0;
      excl_id_q   <= '0;
      excl_word_q <= '0;
      r_excl_q    <= 1'b0;
      w_exok_q    <= 1'b0;
      w_block_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_exok_q  <= s_axi.s_axi_awlock && excl_match;
        w_block_q <= s_axi.s_axi_awlock && !excl_match;
        if (s_axi.s_axi_awlock) excl_v_q <= 1'b0;
      end
      if (w_hs && (word_of(w_addr_q) == excl_word_q)) excl_v_q <= 1'b0;
      if (ar_hs) begin
        r_excl_q <= s_axi.s_axi_arlock;
        if (s_axi.s_axi_arlock) begin
          excl_v_q    <= 1'b1;
          excl_id_q   <= s_axi.s_axi_arid;
          excl_word_q <= word_of(s_axi.s_axi_araddr);
        end
      end
    end
  end
`endif

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = (w_state_q == W_BURST);
  assign s_axi.s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi.s_axi_bid     = w_id_q;
  assign s_axi.s_axi_bresp   = bresp;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign s_axi.s_axi_rlast   = rlast_q;
  assign s_axi.s_axi_rid     = rid_q;
endmodule

// File: doc/axi_ram_burst.md
AXI_RAM_BURST -- requirements
Module: axi_ram_burst

Interface
REQ-001 DATA_WIDTH, 32, data bus bits; power of two, 8..512.
REQ-002 ADDR_WIDTH, 16, byte address bits.
REQ-003 ID_WIDTH, 8, AXI ID bits.
REQ-004 DEPTH, 1024, memory words of DATA_WIDTH; SHALL be <= 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 s_axi_aw{id,addr,len,size,burst,lock,valid}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/1  write address; s_axi_awready out 1.
REQ-008 s_axi_w{data,strb,last,valid}  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data; s_axi_wready out 1.
REQ-009 s_axi_b{id,resp,valid}  out  ID_WIDTH/2/1  write response; s_axi_bready in 1.
REQ-010 s_axi_ar{id,addr,len,size,burst,lock,valid}  in  as AW  read address; s_axi_arready out 1.
REQ-011 s_axi_r{id,data,resp,last,valid}  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; s_axi_rready in 1.

Function
REQ-012 Read and write engines SHALL run independently and concurrently. A same-cycle read and write to one word SHALL return the old data.
REQ-013 Write FSM SHALL be IDLE (awready=1) -> BURST on AW handshake -> RESP after the final W beat -> IDLE on B handshake.
REQ-014 On the AW handshake the block SHALL capture id, addr, len, burst, and size clamped to log2(DATA_WIDTH/8).
REQ-015 In BURST, wready SHALL be 1 and one beat SHALL be accepted per cycle.
REQ-016 Burst termination SHALL follow the len count; wlast SHALL be ignored.
REQ-017 Each accepted beat SHALL write only the byte lanes whose wstrb bit is set.
REQ-018 bvalid SHALL assert the cycle after the last W handshake and hold until bready; bid SHALL equal the captured id.
REQ-019 Read FSM SHALL be IDLE (arready=1) -> BURST on AR handshake -> IDLE after the final beat is issued.
REQ-020 In BURST, a beat SHALL issue when !rvalid || rready; the first rvalid SHALL appear on the 2nd rising edge after the AR handshake.
REQ-021 Reads SHALL sustain 1 beat/cycle while rready=1.
REQ-022 rlast SHALL mark beat len.
REQ-023 rid/rdata/rresp/rlast SHALL hold stable while rvalid && !rready.
REQ-024 Address step: FIXED(00) SHALL keep the address; INCR(01) SHALL add 1<<size.
REQ-025 WRAP(10) SHALL use mask=((len+1)<<size)-1 and next=(addr&~mask)|((addr+(1<<size))&mask).
REQ-026 WRAP with len not in {1,3,7,15}, WRAP with start unaligned to size, and burst 11 SHALL each be an illegal burst.
REQ-027 For an illegal burst the block SHALL still consume/produce len+1 beats, perform no memory write, return rdata 0, and respond SLVERR (10).
REQ-028 A beat whose word index >= DEPTH SHALL not write memory, SHALL return rdata 0, and SHALL carry rresp SLVERR.
REQ-029 bresp SHALL be SLVERR if any beat in the burst errored, else OKAY (00).
REQ-030 arready/awready SHALL reassert the cycle after the read burst's final beat issues / after the B handshake, respectively.

Reset
REQ-031 While rst_n=0 at a clock edge: both FSMs SHALL go IDLE; awready, wready, bvalid, arready, rvalid, rlast SHALL be 0; exclusive monitor SHALL be cleared.
REQ-032 awready and arready SHALL be 1 on the first cycle after rst_n deasserts.
REQ-033 Reset mid-burst SHALL abandon the burst with no B/R completion; memory contents SHALL NOT be cleared.

Configuration
REQ-034 Macro AXI_RAM_BURST_EXCL_EN defined: a single exclusive monitor SHALL be built.
REQ-035 With the macro, an arlock=1 read SHALL record {id, start word}, set the monitor valid, and return rresp EXOKAY (01).
REQ-036 With the macro, an awlock=1 write SHALL write data and respond bresp EXOKAY only if the monitor is valid and id and start word match, then clear the monitor.
REQ-037 With the macro, an awlock=1 write that fails the match SHALL perform no write and respond OKAY.
REQ-038 With the macro, any write beat to the monitored word SHALL clear the monitor.
REQ-039 Macro undefined: awlock/arlock SHALL be ignored, EXOKAY SHALL never be returned, and no monitor logic SHALL exist.

Verification
REQ-040 INCR len=3 size=2 at 0x100, data 11,22,33,44, strb F -> bresp 00; readback gives 11,22,33,44 with rlast on beat 4 and rresp 00.
REQ-041 WRAP len=3 size=2 at 0x108 -> beats hit 0x108,0x10C,0x100,0x104; a WRAP read from 0x108 returns the same order.
REQ-042 FIXED len=3 writing 1,2,3,4 to 0x40 -> a read of 0x40 returns 4.
REQ-043 DEPTH=1024, 32-bit bus, write/read at 0x1000 -> bresp 10, rresp 10, rdata 0; WRAP len=2 -> SLVERR and memory unchanged.
REQ-044 8-beat read with rready toggling 1,0 -> every beat is seen exactly once and data is held while stalled.
REQ-045 With the macro: exclusive read id 5 at 0x20 -> rresp 01; exclusive write id 5 at 0x20 -> bresp 01 and data written; repeated exclusive write -> bresp 00 and memory unchanged.
